snoop_bus_arbiter: RTL and testbench



---
 rtl/snoop_bus_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: serialises the one-cycle miss/invalidate messages of
// NUM_CPU nodes onto a 13-bit coherence bus. Each transaction runs through
// IDLE -> BCAST -> SNOOP -> REPLY, with every output registered.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN (round-robin winner
// selection; when undefined the lowest pending index wins).
//
// Bus field layout: [12] write_back, [11] abort, [10] valid/reply,
// [9] readMiss, [8] writeMiss, [7] invalidate, [6:4] addr, [3:0] data.

// Per-node capture lane: holds the pending flag and the latched message.
module snoop_arb_lane (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] req,      // bus_out[10:4] of this node
  input  logic       clr,      // node was granted this cycle
  output logic       pend,
  output logic [5:0] msg
);
  logic       pend_q, pend_d;
  logic [5:0] msg_q, msg_d;

  // A new request only lands while the node is not pending; set beats clear.
  always_comb begin
    pend_d = pend_q;
    msg_d  = msg_q;
    if (clr) pend_d = 1'b0;
    if (req[6] && !pend_q) begin
      pend_d = 1'b1;
      msg_d  = req[5:0];
    end
  end

  // Capture registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      pend_q <= pend_d;
      msg_q  <= msg_d;
    end
  end

  assign pend = pend_q;
  assign msg  = msg_q;
endmodule

module snoop_bus_arbiter #(
  parameter int NUM_CPU = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [13*NUM_CPU-1:0] cpu_bus_out,
  output logic [13*NUM_CPU-1:0] cpu_bus_in,
  output logic [NUM_CPU-1:0]    grant,
  output logic                  busy,
  output logic [2:0]            mem_addr,
  input  logic [3:0]            mem_rdata,
  output logic [3:0]            mem_wdata,
  output logic                  mem_we
);
  localparam int IW = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  typedef enum logic [1:0] {IDLE, BCAST, SNOOP, REPLY} state_e;

  state_e                     state_q, state_d;
  logic [NUM_CPU-1:0][12:0]   bus_out_a;
  logic [NUM_CPU-1:0][12:0]   bus_in_q, bus_in_d;
  logic [NUM_CPU-1:0]         grant_q, grant_d;
  logic [NUM_CPU-1:0]         pend, pend_clr;
  logic [NUM_CPU-1:0][5:0]    msg_a;
  logic [IW-1:0]              win_q, win_d;
  logic [5:0]                 cur_msg_q, cur_msg_d;
  logic [2:0]                 mem_addr_q, mem_addr_d;
  logic [3:0]                 mem_wdata_q, mem_wdata_d;
  logic                       mem_we_q, mem_we_d;
  logic                       busy_q, busy_d;
  logic                       any;
  logic [IW-1:0]              sel;
  logic                       snp_hit;
  logic [3:0]                 snp_data;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]              ptr_q, ptr_d;
  int                         j;
`endif

  assign bus_out_a = cpu_bus_out;

  genvar g;
  generate
    for (g = 0; g < NUM_CPU; g++) begin : g_lane
      snoop_arb_lane u_lane (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (bus_out_a[g][10:4]),
        .clr     (pend_clr[g]),
        .pend    (pend[g]),
        .msg     (msg_a[g])
      );
    end
  endgenerate

  // Winner selection among pending nodes.
  always_comb begin
    any = 1'b0;
    sel = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    j = 0;
    for (int k = 0; k < NUM_CPU; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_CPU) j = j - NUM_CPU;
      if (!any && pend[j]) begin
        any = 1'b1;
        sel = IW'(j);
      end
    end
`else
    for (int k = 0; k < NUM_CPU; k++) begin
      if (!any && pend[k]) begin
        any = 1'b1;
        sel = IW'(k);
      end
    end
`endif
  end

  // Snoop response: lowest-index non-requester asserting write_back or abort
  // supplies the data; otherwise memory does.
  always_comb begin
    snp_hit  = 1'b0;
    snp_data = mem_rdata;
    for (int i = 0; i < NUM_CPU; i++) begin
      if (!snp_hit && (IW'(i) != win_q) && (bus_out_a[i][12] || bus_out_a[i][11])) begin
        snp_hit  = 1'b1;
        snp_data = bus_out_a[i][3:0];
      end
    end
  end

  // Transaction FSM; next-cycle bus values are computed here so every
  // output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    win_d       = win_q;
    cur_msg_d   = cur_msg_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    bus_in_d    = '0;
    pend_clr    = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d       = BCAST;
          win_d         = sel;
          grant_d       = '0;
          grant_d[sel]  = 1'b1;
          pend_clr[sel] = 1'b1;
          cur_msg_d     = msg_a[sel];
          mem_addr_d    = msg_a[sel][2:0];
          for (int i = 0; i < NUM_CPU; i++)
            if (IW'(i) != sel) bus_in_d[i] = {3'b000, msg_a[sel], 4'b0000};
`ifdef BUS_ARB_ROUND_ROBIN_EN
          ptr_d = (sel == IW'(NUM_CPU - 1)) ? '0 : sel + 1'b1;
`endif
        end
      end
      BCAST: state_d = SNOOP;
      SNOOP: begin
        state_d         = REPLY;
        bus_in_d[win_q] = {3'b001, cur_msg_q, snp_data};
        mem_we_d        = snp_hit;
        mem_wdata_d     = snp_hit ? snp_data : 4'h0;
      end
      REPLY: begin
        state_d     = IDLE;
        grant_d     = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      win_q       <= '0;
      cur_msg_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      bus_in_q    <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      win_q       <= win_d;
      cur_msg_q   <= cur_msg_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      bus_in_q    <= bus_in_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign cpu_bus_in = bus_in_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter (NUM_CPU=3). Memory is a ROM model
// returning {addr,0} one cycle after the address, so memory[5]=4'hA.
module tb_snoop_bus_arbiter;
  logic        clock;
  logic        reset_n;
  logic [38:0] cpu_bus_out;
  logic [38:0] cpu_bus_in;
  logic [2:0]  grant;
  logic        busy;
  logic [2:0]  mem_addr;
  logic [3:0]  mem_rdata;
  logic [3:0]  mem_wdata;
  logic        mem_we;
  logic [12:0] bo [3];

  int tests = 0;
  int fails = 0;

  assign cpu_bus_out = {bo[2], bo[1], bo[0]};

  snoop_bus_arbiter #(.NUM_CPU(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_bus_out (cpu_bus_out),
    .cpu_bus_in  (cpu_bus_in),
    .grant       (grant),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) mem_rdata <= {mem_addr, 1'b0};

  function automatic logic [12:0] bin(input int i);
    return cpu_bus_in[13*i +: 13];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_bo();
    bo[0] = '0; bo[1] = '0; bo[2] = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clr_bo();
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL reset_grant got %b exp 000", grant); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (cpu_bus_in !== 39'h0) begin fails++; $display("FAIL reset_bus_in got %h exp 0", cpu_bus_in); end
    tests++; if ({mem_we, mem_wdata, mem_addr} !== 8'h00) begin fails++; $display("FAIL reset_mem got we=%b wd=%h a=%h exp 0", mem_we, mem_wdata, mem_addr); end
  endtask

  task automatic test_read_miss();
    bo[0] = 13'h0650;                          // readMiss addr 5
    step(); clr_bo();                          // capture edge c
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL rm_no_grant_at_c got %b exp 000", grant); end
    step();                                    // c+1: BCAST
    tests++; if (grant !== 3'b001 || busy !== 1'b1) begin fails++; $display("FAIL rm_grant got %b busy %b exp 001 1", grant, busy); end
    tests++; if (mem_addr !== 3'd5) begin fails++; $display("FAIL rm_mem_addr got %0d exp 5", mem_addr); end
    tests++; if (bin(1) !== 13'h0250 || bin(2) !== 13'h0250 || bin(0) !== 13'h0) begin fails++; $display("FAIL rm_bcast got %h %h %h exp 0 250 250", bin(0), bin(1), bin(2)); end
    step();                                    // c+2: SNOOP
    tests++; if (cpu_bus_in !== 39'h0) begin fails++; $display("FAIL rm_snoop_quiet got %h exp 0", cpu_bus_in); end
    step();                                    // c+3: REPLY
    tests++; if (bin(0) !== 13'h065A) begin fails++; $display("FAIL rm_reply got %h exp 065a", bin(0)); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rm_no_we got %b exp 0", mem_we); end
    step();                                    // c+4: IDLE
    tests++; if (busy !== 1'b0 || grant !== 3'b000 || cpu_bus_in !== 39'h0) begin fails++; $display("FAIL rm_idle got busy %b grant %b in %h exp 0", busy, grant, cpu_bus_in); end
  endtask

  task automatic test_write_back();
    bo[1] = 13'h0620;                          // readMiss addr 2
    step(); clr_bo();
    step();
    tests++; if (grant !== 3'b010) begin fails++; $display("FAIL wb_grant got %b exp 010", grant); end
    step();                                    // SNOOP
    bo[2] = 13'h1007;                          // write_back, data 7
    step(); clr_bo();                          // REPLY
    tests++; if (bin(1) !== 13'h0627) begin fails++; $display("FAIL wb_reply got %h exp 0627", bin(1)); end
    tests++; if (mem_we !== 1'b1 || mem_addr !== 3'd2 || mem_wdata !== 4'h7) begin fails++; $display("FAIL wb_mem got we=%b a=%0d wd=%h exp 1 2 7", mem_we, mem_addr, mem_wdata); end
    step();
    tests++; if (mem_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL wb_we_pulse got we=%b busy=%b exp 0 0", mem_we, busy); end
  endtask

  task automatic test_order();
    logic [2:0] exp2, exp3;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    exp2 = 3'b100; exp3 = 3'b001;
`else
    exp2 = 3'b001; exp3 = 3'b100;
`endif
    do_reset();
    bo[0] = 13'h0610; bo[2] = 13'h0630;
    step(); clr_bo();                          // c
    step();                                    // c+1
    tests++; if (grant !== 3'b001) begin fails++; $display("FAIL order_first got %b exp 001", grant); end
    step(); step();                            // c+3 REPLY
    bo[0] = 13'h0610;
    step(); clr_bo();                          // c+4 IDLE, node 0 captured
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL order_idle got busy %b exp 0", busy); end
    step();                                    // c+5
    tests++; if (grant !== exp2) begin fails++; $display("FAIL order_second got %b exp %b", grant, exp2); end
    step(); step(); step(); step();            // c+9
    tests++; if (grant !== exp3) begin fails++; $display("FAIL order_third got %b exp %b", grant, exp3); end
    step(); step(); step(); step();
  endtask

  task automatic test_invalidate();
    bo[2] = 13'h04B0;                          // invalidate addr 3
    step(); clr_bo();
    step();
    tests++; if (grant !== 3'b100) begin fails++; $display("FAIL inv_grant got %b exp 100", grant); end
    tests++; if (bin(0) !== 13'h00B0 || bin(1) !== 13'h00B0 || bin(2) !== 13'h0) begin fails++; $display("FAIL inv_bcast got %h %h %h exp b0 b0 0", bin(0), bin(1), bin(2)); end
    step(); step();
    tests++; if (bin(2) !== 13'h04B6 || bin(0) !== 13'h0) begin fails++; $display("FAIL inv_reply got %h exp 04b6", bin(2)); end
    step();
  endtask

  task automatic test_reset_mid();
    logic bad;
    bo[0] = 13'h0640;
    step(); clr_bo();
    step(); step();                            // SNOOP
    bo[2] = 13'h1003;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; clr_bo();
    tests++; if (busy !== 1'b0 || grant !== 3'b000 || cpu_bus_in !== 39'h0 || mem_we !== 1'b0) begin fails++; $display("FAIL rst_mid got busy %b grant %b in %h we %b exp 0", busy, grant, cpu_bus_in, mem_we); end
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (mem_we !== 1'b0 || grant !== 3'b000) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL rst_no_replay got %b exp 0", bad); end
  endtask

  task automatic test_two_responders();
    bo[1] = 13'h0660;                          // readMiss addr 6
    step(); clr_bo();
    step(); step();                            // SNOOP
    bo[0] = 13'h1003; bo[1] = 13'h1001; bo[2] = 13'h1009;
    step(); clr_bo();                          // REPLY
    tests++; if (bin(1) !== 13'h0663) begin fails++; $display("FAIL two_resp_reply got %h exp 0663", bin(1)); end
    tests++; if (mem_we !== 1'b1 || mem_wdata !== 4'h3) begin fails++; $display("FAIL two_resp_mem got we=%b wd=%h exp 1 3", mem_we, mem_wdata); end
    step();
  endtask

  task automatic test_abort();
    bo[2] = 13'h0610;                          // readMiss addr 1
    step(); clr_bo();
    step(); step();
    bo[0] = 13'h0805;                          // abort, data 5
    step(); clr_bo();
    tests++; if (bin(2) !== 13'h0615) begin fails++; $display("FAIL abort_reply got %h exp 0615", bin(2)); end
    tests++; if (mem_we !== 1'b1 || mem_wdata !== 4'h5 || mem_addr !== 3'd1) begin fails++; $display("FAIL abort_mem got we=%b wd=%h a=%0d exp 1 5 1", mem_we, mem_wdata, mem_addr); end
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    clr_bo();
    test_reset();
    test_read_miss();
    test_write_back();
    test_order();
    test_invalidate();
    test_reset_mid();
    test_two_responders();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
